// File: rtl/calc_pkg.sv
// Shared constants for the calculator sequencer: ALU op encodings, key codes
// and the sequencer state enumeration.
package calc_pkg;

    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0001;
    localparam logic [3:0] OP_STOP = 4'b0000;

    localparam logic [4:0] KEY_ADD  = 5'b1_0000;
    localparam logic [4:0] KEY_SUB  = 5'b1_0001;
    localparam logic [4:0] KEY_MUL  = 5'b1_0010;
    localparam logic [4:0] KEY_DIV  = 5'b1_0011;
    localparam logic [4:0] KEY_EQ   = 5'b1_0100;
    localparam logic [4:0] KEY_CLR  = 5'b1_0101;
    localparam logic [4:0] KEY_SIGN = 5'b1_0110;

    localparam int CNT_W = 6;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4,
        ST_FLUSH   = 3'd5
    } state_e;

    function automatic logic [3:0] key_to_op(input logic [4:0] code);
        case (code)
            KEY_ADD: return OP_ADD;
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            KEY_DIV: return OP_DIV;
            default: return OP_STOP;
        endcase
    endfunction

endpackage

// File: rtl/calc_seq.sv
// Operand/operator sequencer in front of the calculator ALU: collects keys,
// issues the operation, runs the busy handshake and captures the result.
module calc_seq
    import calc_pkg::*;
#(
    parameter int ADD_CYCLES   = 8,
    parameter int BUSY_TIMEOUT = 4,
    parameter int MAX_CYCLES   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    output logic       key_ready,
    output logic       alu_rst,
    output logic       alu_sign,
    output logic [3:0] alu_op,
    output logic [3:0] alu_data1,
    output logic [3:0] alu_data2,
    input  logic       alu_busy,
    input  logic [7:0] alu_o,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       err
);

    localparam logic [CNT_W-1:0] ADD_LAST = CNT_W'(ADD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HI_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LO_LAST  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         a_q, a_d, b_q, b_d, op_q, op_d, alu_op_q, alu_op_d;
    logic               sign_q, sign_d, err_q, err_d;
    logic [7:0]         result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic               alu_rst_q, alu_rst_d, key_ready_q, key_ready_d;

    logic key_digit_s, key_op_s, key_eq_s, key_clr_s, key_sign_s, issuing_s;

    // Key decode; digits carry their value in the low nibble.
    always_comb begin
        key_digit_s = key_valid && !key_code[4];
        key_op_s    = key_valid && (key_code inside {KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV});
        key_eq_s    = key_valid && (key_code == KEY_EQ);
        key_clr_s   = key_valid && (key_code == KEY_CLR);
        key_sign_s  = key_valid && (key_code == KEY_SIGN);
    end

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        sign_d         = sign_q;
        err_d          = err_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        issuing_s      = 1'b0;

        if (key_clr_s) begin
            state_d = ST_FLUSH;
            a_d     = 4'd0;
            b_d     = 4'd0;
            op_d    = OP_STOP;
            err_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ENTER_A: begin
                    if (key_digit_s) begin
                        a_d   = key_code[3:0];
                        err_d = 1'b0;
                    end else if (key_op_s) begin
                        op_d    = key_to_op(key_code);
                        state_d = ST_ENTER_B;
                        err_d   = 1'b0;
                    end else if (key_sign_s) begin
                        sign_d = ~sign_q;
                        err_d  = 1'b0;
                    end else begin
                        err_d = err_q;
                    end
                end
                ST_ENTER_B: begin
                    if (key_digit_s) begin
                        b_d   = key_code[3:0];
                        err_d = 1'b0;
                    end else if (key_op_s) begin
                        op_d  = key_to_op(key_code);
                        err_d = 1'b0;
                    end else if (key_eq_s) begin
                        state_d = ST_ISSUE;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                    end else if (key_sign_s) begin
                        sign_d = ~sign_q;
                        err_d  = 1'b0;
                    end else begin
                        err_d = err_q;
                    end
                end
                ST_ISSUE: begin
                    case (op_q)
                        OP_ADD, OP_SUB: begin
                            // The add path has no busy; the result settles after a fixed hold.
                            if (cnt_q == ADD_LAST) begin
                                result_d       = alu_o;
                                result_valid_d = 1'b1;
                                state_d        = ST_FLUSH;
                            end else begin
                                cnt_d = cnt_q + CNT_ONE;
                            end
                        end
                        OP_MUL: begin
                            state_d = ST_WAIT_HI;
                            cnt_d   = '0;
                        end
                        OP_DIV: begin
                            if (b_q == 4'd0) begin
                                err_d          = 1'b1;
                                result_d       = 8'd0;
                                result_valid_d = 1'b1;
                                state_d        = ST_FLUSH;
                            end else begin
                                state_d = ST_WAIT_HI;
                                cnt_d   = '0;
                            end
                        end
                        default: state_d = ST_FLUSH;
                    endcase
                end
                ST_WAIT_HI: begin
                    if (alu_busy) begin
                        state_d = ST_WAIT_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == HI_LAST) begin
                        err_d   = 1'b1;
                        state_d = ST_FLUSH;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_LO: begin
                    if (!alu_busy) begin
                        result_d       = alu_o;
                        result_valid_d = 1'b1;
                        state_d        = ST_FLUSH;
                    end else if (cnt_q == LO_LAST) begin
                        err_d   = 1'b1;
                        state_d = ST_FLUSH;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_FLUSH: state_d = ST_ENTER_A;
                default:  state_d = ST_ENTER_A;
            endcase
        end

        key_ready_d = (state_d == ST_ENTER_A) || (state_d == ST_ENTER_B);
        alu_rst_d   = (state_d == ST_FLUSH);
        // A divide by zero never reaches the ALU, so its op stays at STOP.
        if ((state_d == ST_ISSUE) || (state_d == ST_WAIT_HI) || (state_d == ST_WAIT_LO)) begin
            issuing_s = !((op_d == OP_DIV) && (b_d == 4'd0));
        end else begin
            issuing_s = 1'b0;
        end
        if (issuing_s) begin
            alu_op_d = op_d;
        end else begin
            alu_op_d = OP_STOP;
        end
    end

    // Sequencer state, operand latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_ENTER_A;
            cnt_q          <= '0;
            a_q            <= 4'd0;
            b_q            <= 4'd0;
            op_q           <= OP_STOP;
            sign_q         <= 1'b0;
            err_q          <= 1'b0;
            result_q       <= 8'd0;
            result_valid_q <= 1'b0;
            alu_rst_q      <= 1'b0;
            alu_op_q       <= OP_STOP;
            key_ready_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            sign_q         <= sign_d;
            err_q          <= err_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            alu_rst_q      <= alu_rst_d;
            alu_op_q       <= alu_op_d;
            key_ready_q    <= key_ready_d;
        end
    end

    assign key_ready    = key_ready_q;
    assign alu_rst      = alu_rst_q;
    assign alu_sign     = sign_q;
    assign alu_op       = alu_op_q;
    assign alu_data1    = a_q;
    assign alu_data2    = b_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err          = err_q;

endmodule

// File: tb/tb_calc_seq.sv
// Self-checking bench for calc_seq: directed scenarios plus randomized
// calculations checked against an arithmetic reference model.
module tb_calc_seq;

    localparam logic [4:0] K_ADD = 5'h10;
    localparam logic [4:0] K_SUB = 5'h11;
    localparam logic [4:0] K_MUL = 5'h12;
    localparam logic [4:0] K_DIV = 5'h13;
    localparam logic [4:0] K_EQ  = 5'h14;
    localparam logic [4:0] K_CLR = 5'h15;
    localparam logic [4:0] K_SGN = 5'h16;

    logic       clk, rst, key_valid, key_ready, alu_rst, alu_sign, alu_busy;
    logic       result_valid, err;
    logic [4:0] key_code;
    logic [3:0] alu_op, alu_data1, alu_data2;
    logic [7:0] alu_o, result;

    int         n_cmp, n_fail;
    int         m_a, m_b, m_entry;
    logic [4:0] m_opk;
    logic       m_sign, m_err;
    logic [7:0] m_result;

    calc_seq #(.ADD_CYCLES(8), .BUSY_TIMEOUT(4), .MAX_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .alu_rst(alu_rst), .alu_sign(alu_sign),
        .alu_op(alu_op), .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_busy(alu_busy), .alu_o(alu_o), .result(result),
        .result_valid(result_valid), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input logic [4:0] k);
        case (k)
            K_ADD:   return 4'b1000;
            K_SUB:   return 4'b0100;
            K_MUL:   return 4'b0010;
            K_DIV:   return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    // Plain integer arithmetic; divide packs quotient high, remainder low.
    function automatic logic [7:0] ref_calc(input int a, input int b, input logic [4:0] k, input logic sgn);
        int x, y, r;
        logic [31:0] rv;
        x = (sgn && a > 7) ? a - 16 : a;
        y = (sgn && b > 7) ? b - 16 : b;
        r = 0;
        case (k)
            K_ADD: r = x + y;
            K_SUB: r = x - y;
            K_MUL: r = x * y;
            K_DIV: if (y != 0) r = (((x / y) & 15) << 4) | ((x % y) & 15);
            default: r = 0;
        endcase
        rv = 32'(r);
        return rv[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
        key_code  = 5'h00;
        if (k == K_CLR) begin
            m_a = 0; m_b = 0; m_opk = 5'h00; m_err = 1'b0; m_entry = 2;
        end else if (m_entry != 2) begin
            if (!k[4]) begin
                if (m_entry == 0) m_a = int'(k[3:0]);
                else m_b = int'(k[3:0]);
                m_err = 1'b0;
            end else if (k inside {K_ADD, K_SUB, K_MUL, K_DIV}) begin
                m_opk = k; m_entry = 1; m_err = 1'b0;
            end else if (k == K_SGN) begin
                m_sign = ~m_sign; m_err = 1'b0;
            end else if (k == K_EQ && m_entry == 1) begin
                m_entry = 2; m_err = 1'b0;
            end
        end
    endtask

    task automatic reset_model();
        m_a = 0; m_b = 0; m_opk = 5'h00; m_sign = 1'b0; m_err = 1'b0;
        m_result = 8'h00; m_entry = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_key_ready"}, 32'(key_ready), 32'(1));
        check({tag, "_alu_rst"}, 32'(alu_rst), 32'(0));
        check({tag, "_alu_sign"}, 32'(alu_sign), 32'(0));
        check({tag, "_alu_op"}, 32'(alu_op), 32'(0));
        check({tag, "_data1"}, 32'(alu_data1), 32'(0));
        check({tag, "_data2"}, 32'(alu_data2), 32'(0));
        check({tag, "_result"}, 32'(result), 32'(0));
        check({tag, "_valid"}, 32'(result_valid), 32'(0));
        check({tag, "_err"}, 32'(err), 32'(0));
    endtask

    // One full calculation; d = cycles before busy rises, blen = busy length.
    task automatic run_calc(input int a, input int b, input logic [4:0] opk,
                            input int d, input int blen, input bit dup);
        logic [7:0] exp;
        logic [3:0] eop;
        logic       div0;
        press({1'b0, 4'(a)});
        check("err_after_key", 32'(err), 32'(m_err));
        if (dup) press(K_ADD);
        press(opk);
        press({1'b0, 4'(b)});
        press(K_EQ);
        div0 = (m_opk == K_DIV) && (m_b == 0);
        eop  = div0 ? 4'b0000 : onehot(m_opk);
        exp  = div0 ? 8'h00 : ref_calc(m_a, m_b, m_opk, m_sign);
        check("issue_op", 32'(alu_op), 32'(eop));
        check("issue_data1", 32'(alu_data1), 32'(m_a));
        check("issue_data2", 32'(alu_data2), 32'(m_b));
        check("issue_sign", 32'(alu_sign), 32'(m_sign));
        check("issue_not_ready", 32'(key_ready), 32'(0));
        if (div0) begin
            tick();
            m_err = 1'b1; m_result = 8'h00;
            check("div0_valid", 32'(result_valid), 32'(1));
            check("div0_result", 32'(result), 32'(0));
            check("div0_err", 32'(err), 32'(1));
            check("div0_alu_rst", 32'(alu_rst), 32'(1));
            check("div0_op", 32'(alu_op), 32'(0));
        end else if (m_opk == K_ADD || m_opk == K_SUB) begin
            alu_o = ~exp;
            repeat (6) tick();
            tick();
            check("add_hold_op", 32'(alu_op), 32'(eop));
            check("add_not_early", 32'(result_valid), 32'(0));
            alu_o = exp;
            tick();
            m_result = exp;
            check("add_valid", 32'(result_valid), 32'(1));
            check("add_result", 32'(result), 32'(m_result));
            check("add_stop", 32'(alu_op), 32'(0));
            check("add_alu_rst", 32'(alu_rst), 32'(1));
        end else begin
            tick();
            alu_o = ~exp;
            repeat (d) tick();
            alu_busy = 1'b1;
            repeat (blen) tick();
            check("wait_op", 32'(alu_op), 32'(eop));
            check("wait_not_valid", 32'(result_valid), 32'(0));
            alu_busy = 1'b0;
            alu_o = exp;
            tick();
            m_result = exp;
            check("md_valid", 32'(result_valid), 32'(1));
            check("md_result", 32'(result), 32'(m_result));
            check("md_stop", 32'(alu_op), 32'(0));
            check("md_alu_rst", 32'(alu_rst), 32'(1));
            check("md_err", 32'(err), 32'(m_err));
            check("md_data1_stable", 32'(alu_data1), 32'(m_a));
            check("md_data2_stable", 32'(alu_data2), 32'(m_b));
        end
        tick();
        m_entry = 0;
        check("back_ready", 32'(key_ready), 32'(1));
        check("alu_rst_one_cycle", 32'(alu_rst), 32'(0));
        check("valid_one_cycle", 32'(result_valid), 32'(0));
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; key_valid = 1'b0; key_code = 5'h00; alu_busy = 1'b0; alu_o = 8'h00;
        reset_model();
        repeat (3) tick();
        rst = 1'b0;
        check_idle("reset");

        run_calc(3, 4, K_ADD, 0, 1, 1'b0);
        check("tp_add", 32'(result[4:0]), 32'(5'b00111));

        press(K_SGN);
        run_calc(6, 14, K_DIV, 1, 5, 1'b0);
        check("tp_div_signed", 32'(result), 32'(8'hD0));
        press(K_SGN);

        run_calc(5, 3, K_MUL, 3, 32, 1'b0);
        check("tp_mul", 32'(result), 32'(8'h0F));

        run_calc(7, 0, K_DIV, 0, 1, 1'b0);
        run_calc(9, 2, K_SUB, 0, 1, 1'b1);

        press(K_EQ);
        check("eq_in_enter_a_ready", 32'(key_ready), 32'(1));
        check("eq_in_enter_a_op", 32'(alu_op), 32'(0));

        for (int i = 0; i < 24; i++) begin
            int ra, rb, rd, rl;
            logic [4:0] ok;
            ra = int'($urandom_range(15, 0));
            rb = ($urandom_range(5, 0) == 0) ? 0 : int'($urandom_range(15, 0));
            ok = 5'h10 + 5'($urandom_range(3, 0));
            rd = int'($urandom_range(3, 0));
            rl = int'($urandom_range(32, 1));
            if ($urandom_range(3, 0) == 0) press(K_SGN);
            if ($urandom_range(3, 0) == 0) press(5'h1F);
            run_calc(ra, rb, ok, rd, rl, $urandom_range(3, 0) == 0);
        end

        // No busy after a multiply issue: timeout, digits dropped meanwhile.
        press(5'h05); press(K_MUL); press(5'h03); press(K_EQ);
        tick();
        press(5'h09);
        tick(); tick();
        check("hi_wait_no_err_yet", 32'(err), 32'(0));
        check("hi_wait_op", 32'(alu_op), 32'(4'b0010));
        tick();
        m_err = 1'b1;
        check("hi_timeout_err", 32'(err), 32'(1));
        check("hi_timeout_alu_rst", 32'(alu_rst), 32'(1));
        check("hi_timeout_op", 32'(alu_op), 32'(0));
        check("hi_timeout_valid", 32'(result_valid), 32'(0));
        check("hi_digit_dropped", 32'(alu_data1), 32'(m_a));
        check("hi_result_kept", 32'(result), 32'(m_result));
        tick();
        m_entry = 0;
        check("hi_back_ready", 32'(key_ready), 32'(1));
        press(5'h02);
        check("hi_err_cleared", 32'(err), 32'(0));

        // Busy stuck high: 33 high samples trip the timeout.
        press(K_MUL); press(5'h04); press(K_EQ);
        tick();
        alu_busy = 1'b1;
        repeat (32) tick();
        check("lo_no_err_yet", 32'(err), 32'(0));
        check("lo_wait_op", 32'(alu_op), 32'(4'b0010));
        tick();
        m_err = 1'b1;
        check("lo_timeout_err", 32'(err), 32'(1));
        check("lo_timeout_alu_rst", 32'(alu_rst), 32'(1));
        check("lo_timeout_op", 32'(alu_op), 32'(0));
        check("lo_timeout_valid", 32'(result_valid), 32'(0));
        alu_busy = 1'b0;
        tick();
        m_entry = 0;
        check("lo_back_ready", 32'(key_ready), 32'(1));

        // Clear while the ALU is busy.
        press(5'h09); press(K_MUL); press(5'h09); press(K_EQ);
        tick();
        alu_busy = 1'b1;
        repeat (3) tick();
        press(K_CLR);
        check("clr_alu_rst", 32'(alu_rst), 32'(1));
        check("clr_op", 32'(alu_op), 32'(0));
        check("clr_data1", 32'(alu_data1), 32'(m_a));
        check("clr_data2", 32'(alu_data2), 32'(m_b));
        check("clr_err", 32'(err), 32'(0));
        check("clr_result_kept", 32'(result), 32'(m_result));
        check("clr_not_ready", 32'(key_ready), 32'(0));
        alu_busy = 1'b0;
        tick();
        m_entry = 0;
        check("clr_back_ready", 32'(key_ready), 32'(1));
        check("clr_alu_rst_end", 32'(alu_rst), 32'(0));

        // Reset in the middle of a wait.
        if (!m_sign) press(K_SGN);
        press(5'h04); press(K_MUL); press(5'h04); press(K_EQ);
        tick();
        alu_busy = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        alu_busy = 1'b0;
        reset_model();
        check_idle("mid_rst");

        run_calc(2, 3, K_ADD, 0, 1, 1'b0);
        check("after_rst_add", 32'(result), 32'(8'h05));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_seq.md
# calc_seq

Operand/operator sequencer directly upstream of the calculator ALU. It accepts decoded key events, latches operand A, the operator and operand B, then drives the ALU's `sign`/`op`/`data1`/`data2` inputs on `=`. It runs the ALU handshake to completion, captures the 8-bit result, and flushes the ALU back to a clean idle state. Its outputs feed the display stage.

## Interface
- `ADD_CYCLES`, 8: cycles `op` is held for `+`/`-` before capture (ALU add ripples over several registered stages).
- `BUSY_TIMEOUT`, 4: max cycles to wait for `alu_busy` to rise after issuing `*` or `/`.
- `MAX_CYCLES`, 32: max cycles `alu_busy` may stay high.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `key_valid` in 1: one-cycle key strobe.
- `key_code` in 5: `0_vvvv` = operand nibble `vvvv`; `1_0000` `+`, `1_0001` `-`, `1_0010` `*`, `1_0011` `/`, `1_0100` `=`, `1_0101` clear, `1_0110` toggle signed mode; other codes ignored.
- `key_ready` out 1: high when non-clear keys are accepted.
- `alu_rst` out 1: one-cycle ALU flush pulse.
- `alu_sign` out 1: signed mode to ALU.
- `alu_op` out 4: one-hot op (`1000` +, `0100` -, `0010` *, `0001` /, `0000` STOP).
- `alu_data1`, `alu_data2` out 4 each: operands A and B.
- `alu_busy` in 1: ALU busy.
- `alu_o` in 8: ALU result (div: `[7:4]` quotient, `[3:0]` remainder).
- `result` out 8: last captured result.
- `result_valid` out 1: one-cycle pulse on capture.
- `err` out 1: sticky error flag, cleared by the next accepted key.

## Operation
States: ENTER_A, ENTER_B, ISSUE, WAIT_HI, WAIT_LO, FLUSH.

- ENTER_A:
  - A digit overwrites A.
  - An op key latches the op and moves to ENTER_B.
  - `=` is ignored.
- ENTER_B:
  - A digit overwrites B.
  - An op key replaces the latched op.
  - `=` moves to ISSUE.
- ISSUE, `+`/`-`: drive `alu_op` for `ADD_CYCLES` cycles. On the last of those edges, capture `alu_o` and go to FLUSH.
- ISSUE, `/` with B==0: set `err`, set `result`=0, pulse `result_valid`, go to FLUSH. The ALU is never issued.
- ISSUE, `*` or `/` otherwise: drive `alu_op` and go to WAIT_HI.
  - WAIT_HI: on `alu_busy` sampled high, go to WAIT_LO.
  - WAIT_HI: after `BUSY_TIMEOUT` cycles with no busy, set `err` and go to FLUSH.
  - WAIT_LO: on the first edge with `alu_busy` sampled low, capture `alu_o` and go to FLUSH.
  - WAIT_LO: if busy stays high for more than `MAX_CYCLES` cycles, set `err` and go to FLUSH.
- FLUSH: drive `alu_op`=STOP and `alu_rst`=1 for exactly one cycle, then go to ENTER_A.
  - A is preserved, so the result can be chained by re-entering A.
- `alu_op` is STOP in every state except ISSUE/WAIT_HI/WAIT_LO.
- `alu_data1`, `alu_data2` and `alu_sign` are stable from ISSUE through FLUSH.
- Sign toggle is accepted in ENTER_A/ENTER_B only.
- Clear is accepted in every state: abort to FLUSH, zero A, B, op and `err`; keep `result`.
- `key_ready` = state is ENTER_A or ENTER_B.
- A non-clear key with `key_ready` low is dropped silently.

## Timing
- Reset values: `key_ready`=1, `alu_rst`=0, `alu_sign`=0, `alu_op`=0000, `alu_data1`=`alu_data2`=0, `result`=0, `result_valid`=0, `err`=0; state ENTER_A.
- All outputs are registered.
- Key handling: a key sampled at edge N updates state/registers at edge N; `alu_op` changes at that same edge.
- `+`/`-`: `result_valid` pulses `ADD_CYCLES` cycles after the `=` edge.
- `*`/`/`: capture occurs on the edge after the ALU drops busy; `alu_op` goes to STOP and `alu_rst` rises on that same edge.
- Clear and `=` in the same cycle cannot occur (single key bus).
- `rst` mid-operation: immediate return to reset values. The ALU is reset by the shared `rst`.

## Structure
- Shared package `calc_pkg`: ALU op one-hot constants (ADD, SUB, MUL, DIV, STOP), key code constants, state enum.
- Single module. Contents: one state register, one 6-bit cycle counter shared across ADD hold and both timeouts, latches for A/B/op/sign.
- No sub-module is warranted.

## Test plan
- Keys 3, +, 4, = -> `alu_op`=1000 for 8 cycles; `result[4:0]`=00111; `result_valid` pulses once; then one `alu_rst` pulse.
- Signed mode, keys 6, /, 1110 (-2), = -> WAIT_HI, then WAIT_LO; `result`=1101_0000 (quotient -3, remainder 0); `alu_op`=STOP on the capture edge.
- Keys 5, *, 3, = -> `result[7:0]`=0000_1111; `err`=0; ENTER_A afterwards with `key_ready`=1.
- Keys 7, /, 0, = -> no ALU issue; `err`=1; `result`=0; next key clears `err`.
- Hold `alu_busy` low after `*` issue -> `err` after 4 cycles; FLUSH; digits during WAIT_HI are ignored.
- Clear during WAIT_LO -> FLUSH next cycle (`alu_rst`=1, op STOP); A=B=0; `result` unchanged. Mid-WAIT `rst` -> all reset values.
